// File: rtl/frame_wb_pkg.sv
// frame_writeback shared definitions
// widths, frame size and FSM encoding
package frame_wb_pkg;

  localparam int WB_ADDR_W       = 15;
  localparam int WB_DATA_W       = 24;
  localparam int WB_FRAME_PIXELS = 18400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_t;

endpackage

// File: rtl/frame_writeback_if.sv
// frame_writeback bus interface
// pixel stream in, BRAM write port out
interface frame_writeback_if
  import frame_wb_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) ();

  logic              done_in;
  logic [7:0]        red_i;
  logic [7:0]        green_i;
  logic [7:0]        blue_i;
  logic              mem_gnt;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport master (
    output done_in, red_i, green_i, blue_i,
    output mem_gnt,
    input  ena, wea, addra, dina
  );

  modport slave (
    input  done_in, red_i, green_i, blue_i,
    input  mem_gnt,
    output ena, wea, addra, dina
  );

endinterface

// File: rtl/wb_fifo2.sv
// two-entry synchronous FIFO
// caller guarantees no push when full without pop
module wb_fifo2 #(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;

  // storage write, no reset needed on data
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (push) r_wp <= ~r_wp;
      if (pop)  r_rp <= ~r_rp;
      unique case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rp];
  assign full  = (r_cnt == 2'd2);
  assign empty = (r_cnt == 2'd0);

endmodule

// File: rtl/frame_writeback.sv
// frame_writeback: pixel stream to BRAM
// raster-order writes through a 2-deep buffer
module frame_writeback
  import frame_wb_pkg::*;
#(
  parameter int ADDR_W       = WB_ADDR_W,
  parameter int DATA_W       = WB_DATA_W,
  parameter int FRAME_PIXELS = WB_FRAME_PIXELS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  frame_writeback_if.slave   bus,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow
);

  localparam int EW = ADDR_W + DATA_W;

  wb_state_t         r_state;
  wb_state_t         w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ovf;
  logic              r_ena;
  logic              r_wea;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;

  logic [EW-1:0]     w_din;
  logic [EW-1:0]     w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_take;
  logic              w_push;
  logic              w_pop;
  logic              w_last;

  assign w_take = (r_state == ST_RUN) && bus.done_in;
  assign w_pop  = bus.mem_gnt && !w_empty;
  assign w_push = w_take && (!w_full || w_pop);
  assign w_last = (r_cnt == ADDR_W'(FRAME_PIXELS - 1));
  assign w_din  = {r_cnt, bus.red_i, bus.green_i, bus.blue_i};

  wb_fifo2 #(.W(EW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next state and status outputs
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_take && w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_empty) w_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // pixel address counter and sticky drop flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_take) begin
      r_cnt <= r_cnt + 1'b1;
      if (!w_push) r_ovf <= 1'b1;
    end
  end

  // registered BRAM port, one write per granted cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ena   <= 1'b0;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
    end else if (w_pop) begin
      r_ena   <= 1'b1;
      r_wea   <= 1'b1;
      r_addra <= w_dout[EW-1 -: ADDR_W];
      r_dina  <= w_dout[DATA_W-1:0];
    end else begin
      r_ena   <= 1'b0;
      r_wea   <= 1'b0;
    end
  end

  assign bus.ena   = r_ena;
  assign bus.wea   = r_wea;
  assign bus.addra = r_addra;
  assign bus.dina  = r_dina;
  assign overflow  = r_ovf;

endmodule

// File: doc/frame_writeback.md
Name: frame_writeback

Overview:
- Write-side counterpart to the pixel-read path. Captures the processed pixel stream from image_processing (done_out plus red_o/green_o/blue_o) and writes one full frame into the result image BRAM port (clka/ena/wea/addra/dina), in raster order.
- A 2-entry buffer absorbs stalls when the BRAM port is not granted. frame_done pulses when the frame is fully written.

Parameters:
- ADDR_W, 15, BRAM address width.
- DATA_W, 24, pixel width {R,G,B}.
- FRAME_PIXELS, 18400, pixels per frame (160x115).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; arms capture of a new frame (honoured only in IDLE).
- done_in  in  1  pixel valid; driven by image_processing done_out. No backpressure toward the source.
- red_i  in  8  pixel red.
- green_i  in  8  pixel green.
- blue_i  in  8  pixel blue.
- mem_gnt  in  1  BRAM port available this cycle.
- ena  out  1  BRAM enable, registered.
- wea  out  1  BRAM write enable ([0:0]), registered.
- addra  out  ADDR_W  BRAM address, registered.
- dina  out  DATA_W  BRAM write data {red,green,blue}, registered.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse when the last write has been issued.
- overflow  out  1  sticky; a pixel was dropped because the buffer was full.

Behaviour:
- Reset (reset==0 at a clk edge), including mid-frame: state=IDLE; ena=0, wea=0, addra=0, dina=0, busy=0, frame_done=0, overflow=0; pixel counter=0; buffer emptied. No write is issued in the following cycle.
- States:
  - IDLE: start=1 → RUN. Clear pixel counter and overflow.
  - RUN: a sample is taken when done_in=1. Each sample is tagged with its address (= pixel counter) and the counter increments. When the sample at counter value FRAME_PIXELS-1 is taken → DRAIN.
  - DRAIN: done_in ignored (no push, no overflow). When the buffer is empty and no write is pending → DONE.
  - DONE: frame_done=1 for exactly one cycle → IDLE.
- start outside IDLE is ignored.
- Buffer: 2 entries, each {addr[ADDR_W], data[DATA_W]}.
  - Push on a RUN sample if not full.
  - If full, the sample is dropped: overflow is set and the counter still increments. This leaves a hole at that address but keeps later pixels at their correct addresses.
  - Simultaneous push and pop when full: pop frees a slot, push succeeds, no overflow.
- Write issue: at an edge where mem_gnt=1 and the buffer is non-empty:
  - pop the head;
  - register ena=1, wea=1, addra=head.addr, dina=head.data for the next cycle.
  - Otherwise register ena=0, wea=0 (addra/dina hold their last value).
  - At most one write per cycle.
- Latency: pixel sampled at edge E0 appears on wea/addra/dina after edge E1 at the earliest (mem_gnt=1 at E1). There is no bypass.
- Throughput: with mem_gnt held at 1, a done_in stream at 1 pixel/cycle sustains with no drops.
- Ordering: writes are in strictly increasing address order. Addresses 0..FRAME_PIXELS-1; addra never wraps within a frame.
- frame_done is asserted in the cycle after the last wea pulse ends, or later.
- busy = (state==RUN || state==DRAIN).

Decomposition:
- Package frame_wb_pkg:
  - ADDR_W, DATA_W, FRAME_PIXELS defaults;
  - state encoding localparams ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE (2-bit).
- One sub-module: wb_fifo2.
  - Generic 2-entry synchronous FIFO, width ADDR_W+DATA_W.
  - Ports: push, pop, din, dout, full, empty.
  - Active-low synchronous reset.
- Top holds the FSM, counter, overflow flag and output registers.

Test Plan:
- Smoke: FRAME_PIXELS=8, start, done_in=1 for 8 cycles, pixels 0x000001..0x000008, mem_gnt=1.
  - Required: 8 consecutive wea pulses, addra 0..7, dina 0x000001..0x000008.
  - Required: frame_done one cycle after the last write; overflow=0.
- Stall absorb: mem_gnt=0 for 2 cycles while 2 pixels (0xAA0000, 0x00BB00) arrive, then mem_gnt=1.
  - Required: both written to addr 0,1 in order; overflow=0.
- Overflow: mem_gnt=0, 3 pixels arrive (0x111111, 0x222222, 0x333333), then mem_gnt=1.
  - Required: writes only to addr 0,1; addr 2 not written; overflow=1 and stays set until next start.
  - Required: the 4th pixel (0x444444) is written to addr 3.
- Reset mid-frame: reset=0 after 3 of 8 pixels accepted.
  - Required: next cycle wea=0, busy=0, addra=0.
  - Required: after a new start, the first write lands at addr 0.
- Ignored inputs: done_in=1 in IDLE, then start during RUN, then extra pixels during DRAIN.
  - Required: no writes in IDLE; no restart; no extra writes; pixel count unaffected.
- Full frame, default parameter: 18400 pixels, pixel value = address.
  - Required: last write addra=18399, dina=0x0047DF; frame_done exactly once.
